cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator processor. Opcode in instr[15:12], address in instr[11:0].
- Owns the PC and IR and drives the single shared memory port through a req/ack handshake.
- Issues one-cycle strobes to the accumulator datapath, which holds ACC and supplies mem_wdata and acc_zero.
- Sits between instruction/data memory and the ALU/accumulator datapath.

---
 rtl/cpu_sequencer_if.sv | 27 ++
 rtl/cpu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer (master) and instruction/data memory (slave).
// Request/acknowledge handshake with a single address and read-data bus.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 12
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator processor.
// Owns PC/IR, drives the shared memory port and strobes the accumulator datapath.
module cpu_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    cpu_sequencer_if.master   mem,
    input  logic              acc_zero,
    output logic              acc_load,
    output logic              acc_add,
    output logic              acc_clear,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic [2:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_CLEAR = 4'b1100;
    localparam logic [3:0] OP_SKIP  = 4'b1101;
    localparam logic [3:0] OP_JUMP  = 4'b1110;
    localparam logic [3:0] OP_ILL   = 4'b1111;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [15:0]       ir_r, ir_nxt_s;
    logic [15:0]       retired_r;
    logic              illegal_r;
    logic              retire_s;
    logic              illegal_set_s;
    logic              req_s, we_s;
    logic [ADDR_W-1:0] addr_s;
    logic              load_s, add_s, clear_s, halted_s;

    // Next-state, memory-port and strobe decode for the sequencer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        ir_nxt_s      = ir_r;
        retire_s      = 1'b0;
        illegal_set_s = 1'b0;
        req_s         = 1'b0;
        we_s          = 1'b0;
        addr_s        = {ADDR_W{1'b0}};
        load_s        = 1'b0;
        add_s         = 1'b0;
        clear_s       = 1'b0;
        halted_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                req_s  = 1'b1;
                addr_s = pc_r;
                if (mem.mem_ack) begin
                    ir_nxt_s    = mem.mem_rdata;
                    pc_nxt_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_of(ir_r))
                    OP_ADD, OP_LOAD: state_nxt_s = S_MEM_RD;
                    OP_STORE:        state_nxt_s = S_MEM_WR;
                    OP_CLEAR: begin
                        clear_s     = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                    OP_SKIP: begin
                        if (acc_zero) begin
                            pc_nxt_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                    OP_JUMP: begin
                        pc_nxt_s    = ir_r[ADDR_W-1:0];
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                    OP_HALT: begin
                        retire_s    = 1'b1;
                        state_nxt_s = S_HALTED;
                    end
                    OP_ILL: begin
                        illegal_set_s = 1'b1;
                        state_nxt_s   = S_HALTED;
                    end
                    default: begin
                        // opcodes 0000-0111 are NOPs
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                endcase
            end
            S_MEM_RD: begin
                req_s  = 1'b1;
                addr_s = ir_r[ADDR_W-1:0];
                if (mem.mem_ack) begin
                    if (opcode_of(ir_r) == OP_ADD) begin
                        add_s = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                req_s  = 1'b1;
                we_s   = 1'b1;
                addr_s = ir_r[ADDR_W-1:0];
                if (mem.mem_ack) begin
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEM_WR;
                end
            end
            S_HALTED: begin
                halted_s    = 1'b1;
                state_nxt_s = S_HALTED;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, PC/IR, retire counter and sticky illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pc_r      <= ADDR_W'(RESET_PC);
            ir_r      <= 16'h0000;
            retired_r <= 16'h0000;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
            if (retire_s) begin
                retired_r <= retired_r + 16'd1;
            end
            if (illegal_set_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Port outputs decode from the state register, so reset drops mem_req at once.
    assign mem.mem_req  = req_s;
    assign mem.mem_we   = we_s;
    assign mem.mem_addr = addr_s;
    assign acc_load     = load_s;
    assign acc_add      = add_s;
    assign acc_clear    = clear_s;
    assign halted       = halted_s;
    assign pc           = pc_r;
    assign ir           = ir_r;
    assign state        = state_r;
    assign illegal      = illegal_r;
    assign retired      = retired_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory/ACC model plus a transaction scoreboard.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        acc_zero;
    logic        acc_load, acc_add, acc_clear;
    logic [11:0] pc;
    logic [15:0] ir;
    logic [2:0]  state;
    logic        halted, illegal;
    logic [15:0] retired;

    cpu_sequencer_if #(.ADDR_W(12)) bus ();

    cpu_sequencer #(.ADDR_W(12), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem       (bus.master),
        .acc_zero  (acc_zero),
        .acc_load  (acc_load),
        .acc_add   (acc_add),
        .acc_clear (acc_clear),
        .pc        (pc),
        .ir        (ir),
        .state     (state),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: ack after ack_delay waiting cycles, optional write blocking, forced late ack
    logic [15:0] mem [0:4095];
    int          ack_delay;
    int          wait_cnt;
    logic        block_wr;
    logic        late_ack;
    logic [15:0] acc;

    assign bus.mem_ack   = (bus.mem_req && (wait_cnt >= ack_delay) && !(block_wr && bus.mem_we)) || late_ack;
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign acc_zero      = (acc == 16'h0000);

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset)          acc <= 16'h0000;
        else if (acc_load)  acc <= bus.mem_rdata;
        else if (acc_add)   acc <= acc + bus.mem_rdata;
        else if (acc_clear) acc <= 16'h0000;
    end

    // monitor: completed transactions {we, add, load, addr} and strobe statistics
    logic [14:0] obs_q[$];
    int add_cnt, load_cnt, clr_cnt, multi_cnt, bad_cnt;
    initial begin
        add_cnt = 0; load_cnt = 0; clr_cnt = 0; multi_cnt = 0; bad_cnt = 0;
    end
    always @(posedge clk) begin
        if (!reset) begin
            if (bus.mem_req && bus.mem_ack)
                obs_q.push_back({bus.mem_we, acc_add, acc_load, bus.mem_addr});
            if (acc_add)   add_cnt   <= add_cnt + 1;
            if (acc_load)  load_cnt  <= load_cnt + 1;
            if (acc_clear) clr_cnt   <= clr_cnt + 1;
            if ((32'(acc_add) + 32'(acc_load) + 32'(acc_clear)) > 32'd1) multi_cnt <= multi_cnt + 1;
            if ((acc_add || acc_load || acc_clear) && state != 3'd2 && state != 3'd3) bad_cnt <= bad_cnt + 1;
        end
    end

    int          passed, total;
    logic [14:0] exp_q[$];
    int          obs_rd;

    function automatic logic [14:0] tx(input logic we, input logic ad, input logic ld, input logic [11:0] a);
        return {we, ad, ld, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        late_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic run_until(input string tag, input logic [2:0] target, input int budget);
        int n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic wait_decode(input string tag, input logic [15:0] irv, input int budget);
        int n = 0;
        while (!(state === 3'd2 && ir === irv) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(ir), 32'(irv));
    endtask

    task automatic sb_check(input string tag);
        logic [14:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) o = obs_q[obs_rd];
            else                       o = 'x;
            obs_rd++;
            check(tag, 32'(o), 32'(e));
        end
        check({tag, "_count"}, 32'(obs_q.size()), 32'(obs_rd));
    endtask

    int base_add, base_clr;

    initial begin
        passed = 0; total = 0; obs_rd = 0;
        reset = 1'b1; start = 1'b0; late_ack = 1'b0; block_wr = 1'b0; ack_delay = 0;

        // ---- reset values and zero-wait LOAD ----
        mem[0] = 16'hA005; mem[5] = 16'h0007; mem[1] = 16'h9000;
        repeat (2) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_req", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}), 32'd0);
        check("rst_flags", 32'({halted, illegal, acc_load, acc_add, acc_clear}), 32'd0);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ld_fetch", 32'({state, bus.mem_req, bus.mem_we, bus.mem_addr}), {16'd0, 3'd1, 1'b1, 1'b0, 12'h000});
        tick();
        check("ld_decode", 32'({state, pc, ir}), {1'b0, 3'd2, 12'h001, 16'hA005});
        tick();
        check("ld_memrd", 32'({state, bus.mem_we, bus.mem_addr}), {16'd0, 3'd3, 1'b0, 12'h005});
        check("ld_strobe", 32'({acc_load, acc_add, acc_clear}), 32'b100);
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h000));
        exp_q.push_back(tx(1'b0, 1'b0, 1'b1, 12'h005));
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h001));
        tick();
        check("ld_after", 32'({state, pc, retired, acc_load}), {3'd1, 12'h001, 16'd1, 1'b0});
        run_until("ld_halt", 3'd5, 20);
        check("ld_acc", 32'(acc), 32'h0007);
        check("ld_retired", 32'(retired), 32'd2);
        sb_check("ld_sb");

        // ---- ADD with 3-cycle delayed ack, then CLEAR, NOP, HALT ----
        mem[0] = 16'h8006; mem[6] = 16'h0003; mem[1] = 16'hC000; mem[2] = 16'h0000; mem[3] = 16'h9000;
        ack_delay = 3;
        do_reset();
        base_add = add_cnt; base_clr = clr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until("add_reach", 3'd3, 40);
        for (int i = 0; i < 3; i++) begin
            check("add_wait", 32'({bus.mem_req, bus.mem_addr, acc_add}), {1'b1, 12'h006, 1'b0});
            tick();
        end
        check("add_ack", 32'({bus.mem_ack, acc_add, acc_load}), 32'b110);
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h000));
        exp_q.push_back(tx(1'b0, 1'b1, 1'b0, 12'h006));
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h001));
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h002));
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h003));
        tick();
        check("add_after", 32'({state, acc_add, retired}), {3'd1, 1'b0, 16'd1});
        check("add_acc", 32'(acc), 32'h0003);
        run_until("add_halt", 3'd5, 100);
        check("add_retired", 32'(retired), 32'd4);
        check("add_once", 32'(add_cnt - base_add), 32'd1);
        check("clr_once", 32'(clr_cnt - base_clr), 32'd1);
        check("clr_acc", 32'(acc), 32'h0000);
        sb_check("add_sb");
        ack_delay = 0;

        // ---- SKIP at 0xFFE with acc_zero = 1 (wraps) ----
        mem[0] = 16'hEFFE; mem[12'hFFE] = 16'hD000;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_decode("skip1_reach", 16'hD000, 20);
        check("skip1_pc_pre", 32'(pc), 32'h0FFF);
        tick();
        check("skip1_pc", 32'({state, pc, retired}), {3'd1, 12'h000, 16'd2});

        // ---- SKIP at 0xFFE with acc_zero = 0 ----
        mem[0] = 16'hA010; mem[16] = 16'h0005; mem[1] = 16'hEFFE;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_decode("skip0_reach", 16'hD000, 30);
        tick();
        check("skip0_pc", 32'({state, pc, retired}), {3'd1, 12'hFFF, 16'd3});

        // ---- JUMP 0x123 then HALT, start ignored ----
        mem[0] = 16'hE123; mem[12'h123] = 16'h9000;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h000));
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h123));
        run_until("jmp_halt", 3'd5, 20);
        check("jmp_pc", 32'({pc, halted, retired}), {12'h124, 1'b1, 16'd2});
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", 32'({state, bus.mem_req}), {3'd5, 1'b0});
        end
        start = 1'b0;
        sb_check("jmp_sb");

        // ---- illegal opcode ----
        mem[0] = 16'hF000;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h000));
        run_until("ill_halt", 3'd5, 20);
        check("ill_flags", 32'({illegal, halted, retired, pc}), {1'b1, 1'b1, 16'd0, 12'h001});
        sb_check("ill_sb");

        // ---- reset during MEM_WR with ack pending, then late ack ----
        mem[0] = 16'hB007;
        block_wr = 1'b1;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(tx(1'b0, 1'b0, 1'b0, 12'h000));
        run_until("wr_reach", 3'd4, 20);
        check("wr_req", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}), {1'b1, 1'b1, 12'h007});
        tick();
        check("wr_stable", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}), {1'b1, 1'b1, 12'h007});
        #2;
        reset = 1'b1;
        #1;
        check("wr_rst_req", 32'({bus.mem_req, state, pc}), {1'b0, 3'd0, 12'h000});
        tick();
        reset = 1'b0;
        late_ack = 1'b1;
        repeat (2) tick();
        check("late_ack", 32'({state, pc, ir, retired}), {3'd0, 12'h000, 16'h0000, 16'h0000});
        late_ack = 1'b0;
        block_wr = 1'b0;
        sb_check("wr_sb");

        check("strobe_excl", 32'(multi_cnt), 32'd0);
        check("strobe_state", 32'(bad_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
